vx_cache_core_rsp_queue: RTL and testbench

VX_CACHE_CORE_RSP_QUEUE -- requirements
Module: VX_cache_core_rsp_queue

---
 rtl/vx_cache_core_rsp_queue.sv | 119 +++++++++++
 tb/tb_vx_cache_core_rsp_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_cache_core_rsp_queue.sv
// Core response queue: FWFT FIFO buffering bank responses for the merge stage.
// Ports: enq_* (valid/ready, per-port pmask/data/idx/tag) in, deq_* out, size, alm_full.
module vx_cache_core_rsp_queue #(
  parameter int NUM_REQS  = 4,
  parameter int NUM_PORTS = 2,
  parameter int WORD_SIZE = 4,
  parameter int TAG_WIDTH = 8,
  parameter int DEPTH     = 4,
  parameter int ALM_FULL  = DEPTH - 1,
  localparam int REQ_SEL_BITS =
    (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int WORD_WIDTH = WORD_SIZE * 8,
  localparam int SIZE_W = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic reset,

  input  logic enq_valid,
  input  logic [NUM_PORTS-1:0] enq_pmask,
  input  logic [NUM_PORTS*WORD_WIDTH-1:0] enq_data,
  input  logic [NUM_PORTS*REQ_SEL_BITS-1:0] enq_idx,
  input  logic [NUM_PORTS*TAG_WIDTH-1:0] enq_tag,
  output logic enq_ready,

  output logic deq_valid,
  output logic [NUM_PORTS-1:0] deq_pmask,
  output logic [NUM_PORTS*WORD_WIDTH-1:0] deq_data,
  output logic [NUM_PORTS*REQ_SEL_BITS-1:0] deq_idx,
  output logic [NUM_PORTS*TAG_WIDTH-1:0] deq_tag,
  input  logic deq_ready,

  output logic [SIZE_W-1:0] size,
  output logic alm_full
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = NUM_PORTS * WORD_WIDTH;
  localparam int IW = NUM_PORTS * REQ_SEL_BITS;
  localparam int TW = NUM_PORTS * TAG_WIDTH;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= 2");
  end

  if (ALM_FULL < 1 || ALM_FULL > DEPTH) begin : g_bad_alm
    $error("ALM_FULL must be in 1..DEPTH");
  end

  logic [NUM_PORTS-1:0] mem_pmask [DEPTH];
  logic [DW-1:0]        mem_data  [DEPTH];
  logic [IW-1:0]        mem_idx   [DEPTH];
  logic [TW-1:0]        mem_tag   [DEPTH];

  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;

  logic full;
  logic empty;
  logic has_data;
  logic push;
  logic pop;

  assign full  = (size == SIZE_W'(DEPTH));
  assign empty = (size == '0);

  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign alm_full  = (size >= SIZE_W'(ALM_FULL));

  // An all-zero mask carries nothing: it is handshaken but dropped.
  if (NUM_PORTS == 1) begin : g_one_port
    assign has_data = 1'b1;
  end else begin : g_multi_port
    assign has_data = |enq_pmask;
  end

  assign push = enq_valid && enq_ready && has_data;
  assign pop  = deq_valid && deq_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      size   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   size <= size + 1'b1;
        2'b01:   size <= size - 1'b1;
        default: size <= size;
      endcase
    end
  end

  // Storage is intentionally not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pmask[wr_ptr] <= enq_pmask;
      mem_data[wr_ptr]  <= enq_data;
      mem_idx[wr_ptr]   <= enq_idx;
      mem_tag[wr_ptr]   <= enq_tag;
    end
  end

  assign deq_pmask = mem_pmask[rd_ptr];
  assign deq_data  = mem_data[rd_ptr];
  assign deq_idx   = mem_idx[rd_ptr];
  assign deq_tag   = mem_tag[rd_ptr];

  a_push_full : assert property (
    @(posedge clk) disable iff (!reset)
    !(push && full));

  a_pop_empty : assert property (
    @(posedge clk) disable iff (!reset)
    !(pop && empty));

endmodule

// File: tb/tb_vx_cache_core_rsp_queue.sv
// Bench for vx_cache_core_rsp_queue: queue model, per-cycle compare, directed cases.
// Drives enq/deq randomly and in directed phases; checks all outputs.
module tb_vx_cache_core_rsp_queue;

  localparam int NP = 2;
  localparam int DEPTH = 4;
  localparam int AF = 3;

  typedef struct {
    logic [NP-1:0]   pmask;
    logic [NP*32-1:0] data;
    logic [NP*2-1:0] idx;
    logic [NP*8-1:0] tag;
  } ent_t;

  logic clk = 0;
  logic reset = 0;
  logic enq_valid = 0;
  logic [NP-1:0] enq_pmask = '0;
  logic [NP*32-1:0] enq_data = '0;
  logic [NP*2-1:0] enq_idx = '0;
  logic [NP*8-1:0] enq_tag = '0;
  logic enq_ready;
  logic deq_valid;
  logic [NP-1:0] deq_pmask;
  logic [NP*32-1:0] deq_data;
  logic [NP*2-1:0] deq_idx;
  logic [NP*8-1:0] deq_tag;
  logic deq_ready = 0;
  logic [2:0] size;
  logic alm_full;

  vx_cache_core_rsp_queue #(
    .NUM_REQS(4), .NUM_PORTS(NP), .WORD_SIZE(4),
    .TAG_WIDTH(8), .DEPTH(DEPTH), .ALM_FULL(AF)
  ) dut (
    .clk(clk), .reset(reset),
    .enq_valid(enq_valid), .enq_pmask(enq_pmask),
    .enq_data(enq_data), .enq_idx(enq_idx),
    .enq_tag(enq_tag), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_pmask(deq_pmask),
    .deq_data(deq_data), .deq_idx(deq_idx),
    .deq_tag(deq_tag), .deq_ready(deq_ready),
    .size(size), .alm_full(alm_full)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  ent_t mq[$];
  int wr_cnt = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Model: plain queue, pop-then-push on each edge.
  always @(negedge reset) begin
    mq.delete();
    wr_cnt = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      automatic bit p_pop = deq_ready && mq.size() > 0;
      automatic bit p_push = enq_valid
        && mq.size() < DEPTH && (|enq_pmask);
      automatic ent_t e;
      e.pmask = enq_pmask;
      e.data = enq_data;
      e.idx = enq_idx;
      e.tag = enq_tag;
      if (p_pop) void'(mq.pop_front());
      if (p_push) begin
        mq.push_back(e);
        wr_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    chk("size", 64'(size), 64'(mq.size()));
    chk("deq_valid", 64'(deq_valid), 64'(mq.size() != 0));
    chk("enq_ready", 64'(enq_ready),
        64'(mq.size() != DEPTH));
    chk("alm_full", 64'(alm_full), 64'(mq.size() >= AF));
    chk("wr_ptr", 64'(dut.wr_ptr), 64'(wr_cnt % DEPTH));
    if (mq.size() != 0) begin
      chk("deq_tag", 64'(deq_tag), 64'(mq[0].tag));
      chk("deq_data", deq_data, mq[0].data);
      chk("deq_idx", 64'(deq_idx), 64'(mq[0].idx));
      chk("deq_pmask", 64'(deq_pmask), 64'(mq[0].pmask));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(bit v, logic [NP-1:0] m,
                         logic [7:0] t);
    enq_valid = v;
    enq_pmask = m;
    enq_tag = {t, t};
    enq_data = {$urandom, $urandom};
    enq_idx = 4'($urandom);
  endtask

  initial begin
    logic [NP*8-1:0] t_exp;
    logic [NP*32-1:0] d_exp;
    logic [NP*2-1:0] i_exp;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_size", 64'(size), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_alm_full", 64'(alm_full), 64'd0);
    reset = 1;
    cyc();

    // Fill with tags 1..4, no draining.
    for (int i = 1; i <= 4; i++) begin
      set_enq(1, 2'b11, 8'(i));
      cyc();
      chk("fill_size", 64'(size), 64'(i));
      chk("fill_alm", 64'(alm_full), 64'(i >= 3));
    end
    set_enq(1, 2'b01, 8'd99);
    cyc();
    chk("full_size", 64'(size), 64'd4);
    chk("full_ready", 64'(enq_ready), 64'd0);
    chk("full_head", 64'(deq_tag), 64'h0101);

    // Drain: tags in order on consecutive cycles.
    set_enq(0, 2'b00, 8'd0);
    deq_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_tag", 64'(deq_tag),
          64'({8'(i), 8'(i)}));
      cyc();
    end
    chk("drain_valid", 64'(deq_valid), 64'd0);
    chk("drain_size", 64'(size), 64'd0);
    deq_ready = 0;

    // Steady state at size 2 with push+pop every cycle.
    set_enq(1, 2'b10, 8'd10);
    cyc();
    set_enq(1, 2'b11, 8'd11);
    cyc();
    deq_ready = 1;
    for (int i = 0; i < 10; i++) begin
      set_enq(1, 2'b01, 8'(12 + i));
      chk("ss_tag", 64'(deq_tag),
          64'({8'(10 + i), 8'(10 + i)}));
      cyc();
      chk("ss_size", 64'(size), 64'd2);
    end
    set_enq(0, 2'b00, 8'd0);
    cyc();
    cyc();
    deq_ready = 0;
    chk("ss_empty", 64'(size), 64'd0);

    // Zero mask: handshaken, dropped.
    set_enq(1, 2'b00, 8'd55);
    chk("zm_ready", 64'(enq_ready), 64'd1);
    cyc();
    chk("zm_size", 64'(size), 64'd0);
    chk("zm_valid", 64'(deq_valid), 64'd0);
    set_enq(0, 2'b00, 8'd0);

    // Empty-queue push latency.
    set_enq(1, 2'b10, 8'd77);
    t_exp = enq_tag;
    d_exp = enq_data;
    i_exp = enq_idx;
    chk("lat_n_valid", 64'(deq_valid), 64'd0);
    cyc();
    set_enq(0, 2'b00, 8'd0);
    chk("lat_n1_valid", 64'(deq_valid), 64'd1);
    chk("lat_tag", 64'(deq_tag), 64'(t_exp));
    chk("lat_data", deq_data, d_exp);
    chk("lat_idx", 64'(deq_idx), 64'(i_exp));
    chk("lat_pmask", 64'(deq_pmask), 64'd2);
    deq_ready = 1;
    cyc();
    deq_ready = 0;

    // Async reset with three entries.
    for (int i = 0; i < 3; i++) begin
      set_enq(1, 2'b11, 8'(40 + i));
      cyc();
    end
    set_enq(0, 2'b00, 8'd0);
    chk("pre_rst_size", 64'(size), 64'd3);
    #1;
    reset = 0;
    #1;
    chk("ar_size", 64'(size), 64'd0);
    chk("ar_valid", 64'(deq_valid), 64'd0);
    chk("ar_ready", 64'(enq_ready), 64'd1);
    cyc();
    reset = 1;
    set_enq(1, 2'b01, 8'd9);
    cyc();
    set_enq(1, 2'b11, 8'd8);
    cyc();
    set_enq(0, 2'b00, 8'd0);
    chk("post_rst_head", 64'(deq_tag), 64'h0909);
    chk("post_rst_ptr", 64'(dut.rd_ptr), 64'd0);
    deq_ready = 1;
    cyc();
    chk("post_rst_2nd", 64'(deq_tag), 64'h0808);
    cyc();
    deq_ready = 0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      set_enq($urandom_range(0, 3) != 0,
              2'($urandom), 8'($urandom));
      deq_ready = ($urandom_range(0, 2) == 0);
      cyc();
    end
    set_enq(0, 2'b00, 8'd0);
    deq_ready = 1;
    repeat (6) cyc();
    chk("final_empty", 64'(size), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
